// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: mode encodings, FSM states, per-bit cell ops.
package usr_pkg;

   typedef enum logic [2:0] {
      USR_HOLD     = 3'b000,
      USR_LOAD     = 3'b001,
      USR_SHL      = 3'b010,
      USR_SHR      = 3'b011,
      USR_ROTL     = 3'b100,
      USR_ROTR     = 3'b101,
      USR_CLEAR    = 3'b110,
      USR_HOLD_ALT = 3'b111
   } usr_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      BURST,
      FIN
   } usr_state_t;

   typedef enum logic [2:0] {
      CELL_HOLD,
      CELL_LOAD,
      CELL_LEFT,
      CELL_RIGHT,
      CELL_CLEAR
   } cell_op_t;

   function automatic logic is_shift(input usr_mode_t m);
      return m inside {USR_SHL, USR_SHR, USR_ROTL, USR_ROTR};
   endfunction

   function automatic logic is_left(input usr_mode_t m);
      return m inside {USR_SHL, USR_ROTL};
   endfunction

endpackage

// File: rtl/usr_cell.sv
// One storage bit of the universal shift register: next-value mux plus flop resetting to its INIT bit.
module usr_cell
   import usr_pkg::*;
#(
   parameter logic INIT_BIT = 1'b0
) (
   input  logic     clk,
   input  logic     rst,
   input  cell_op_t op,
   input  logic     load_bit,
   input  logic     left_bit,
   input  logic     right_bit,
   output logic     q
);

   logic q_next;

   always_comb begin
      q_next = q;
      case (op)
         CELL_LOAD:  q_next = load_bit;
         CELL_LEFT:  q_next = left_bit;
         CELL_RIGHT: q_next = right_bit;
         CELL_CLEAR: q_next = 1'b0;
         default:    q_next = q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= INIT_BIT;
      else     q <= q_next;
   end

endmodule

// File: rtl/universal_shift_reg.sv
// WIDTH-bit universal register: single-cycle hold/load/clear and counted shift/rotate bursts.
module universal_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH = 8,
   parameter logic [WIDTH-1:0] INIT  = '0,
   localparam int              CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       mode,
   input  logic             start,
   input  logic [CNT_W-1:0] shift_cnt,
   input  logic [WIDTH-1:0] din,
   input  logic             sin_l,
   input  logic             sin_r,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
);

   usr_state_t       state, state_next;
   usr_mode_t        mode_lat, op_mode;
   logic [CNT_W-1:0] count, count_next, n_sat;
   cell_op_t         cell_op;
   logic             left_in, right_in;

   assign op_mode = (state == BURST) ? mode_lat : usr_mode_t'(mode);
   assign n_sat   = (shift_cnt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : shift_cnt;

   // State register; busy/done are registered from the FSM so they change only on clk.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         mode_lat <= USR_HOLD;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (state == IDLE && start) mode_lat <= usr_mode_t'(mode);
         busy  <= (state_next == BURST);
         done  <= (state == FIN);
      end
   end

   always_comb begin
      state_next = state;
      count_next = count;
      case (state)
         IDLE: begin
            if (start) begin
               if (is_shift(op_mode) && n_sat > CNT_W'(1)) begin
                  state_next = BURST;
                  count_next = n_sat - CNT_W'(1);
               end else begin
                  state_next = FIN;
                  count_next = '0;
               end
            end
         end
         BURST: begin
            count_next = count - CNT_W'(1);
            if (count == CNT_W'(1)) state_next = FIN;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      cell_op = CELL_HOLD;
      if ((state == IDLE && start) || state == BURST) begin
         case (op_mode)
            USR_LOAD:  cell_op = CELL_LOAD;
            USR_CLEAR: cell_op = CELL_CLEAR;
            USR_SHL, USR_SHR, USR_ROTL, USR_ROTR: begin
               if (state == BURST || n_sat != '0)
                  cell_op = is_left(op_mode) ? CELL_LEFT : CELL_RIGHT;
            end
            default:   cell_op = CELL_HOLD;
         endcase
      end
   end

   assign left_in  = (op_mode == USR_ROTL) ? q[WIDTH-1] : sin_l;
   assign right_in = (op_mode == USR_ROTR) ? q[0]       : sin_r;

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      logic left_bit, right_bit;

      if (i == 0) begin : g_lo
         assign left_bit = left_in;
      end else begin : g_lo_n
         assign left_bit = q[i-1];
      end

      if (i == WIDTH - 1) begin : g_hi
         assign right_bit = right_in;
      end else begin : g_hi_n
         assign right_bit = q[i+1];
      end

      usr_cell #(.INIT_BIT(INIT[i])) u_cell (
         .clk       (clk),
         .rst       (rst),
         .op        (cell_op),
         .load_bit  (din[i]),
         .left_bit  (left_bit),
         .right_bit (right_bit),
         .q         (q[i])
      );
   end

   assign sout_l = q[WIDTH-1];
   assign sout_r = q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, INIT=0) with hand-computed expectations.
module tb_universal_shift_reg;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] mode;
   logic       start;
   logic [3:0] shift_cnt;
   logic [7:0] din;
   logic       sin_l, sin_r;
   logic [7:0] q;
   logic       sout_l, sout_r, busy, done;

   int n_assert = 0;
   int n_fail   = 0;

   universal_shift_reg #(.WIDTH(8), .INIT(8'h00)) dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .start     (start),
      .shift_cnt (shift_cnt),
      .din       (din),
      .sin_l     (sin_l),
      .sin_r     (sin_r),
      .q         (q),
      .sout_l    (sout_l),
      .sout_r    (sout_r),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [7:0] val);
      mode = 3'b001; din = val; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
   endtask

   initial begin
      logic [7:0] exp_q;
      rst = 1'b1; mode = 3'b000; start = 1'b0; shift_cnt = '0;
      din = '0; sin_l = 1'b0; sin_r = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk8("reset_q", q, 8'h00);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);

      // load A5
      mode = 3'b001; din = 8'hA5; start = 1'b1;
      tick();
      start = 1'b0;
      chk8("load_q", q, 8'hA5);
      chk1("load_done_early", done, 1'b0);
      tick();
      chk1("load_done", done, 1'b1);
      tick();
      chk1("load_done_clear", done, 1'b0);
      chk8("load_q_hold", q, 8'hA5);

      // clear
      mode = 3'b110; start = 1'b1;
      tick();
      start = 1'b0;
      chk8("clear_q", q, 8'h00);
      tick();
      chk1("clear_done", done, 1'b1);
      tick();

      // rotate left 3 from 81
      load(8'h81);
      mode = 3'b100; shift_cnt = 4'd3; start = 1'b1;
      tick();
      start = 1'b0; mode = 3'b000;
      chk8("rotl_q1", q, 8'h03);
      chk1("rotl_busy1", busy, 1'b1);
      tick();
      chk8("rotl_q2", q, 8'h06);
      chk1("rotl_busy2", busy, 1'b1);
      tick();
      chk8("rotl_q3", q, 8'h0C);
      chk1("rotl_busy3", busy, 1'b0);
      chk1("rotl_done_early", done, 1'b0);
      tick();
      chk1("rotl_done", done, 1'b1);
      chk8("rotl_q_hold", q, 8'h0C);
      tick();

      // shift right 4 from F0 with sin_r=1, mode toggled mid-burst
      load(8'hF0);
      mode = 3'b011; shift_cnt = 4'd4; sin_r = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; mode = 3'b001; din = 8'h00;
      chk8("shr_q1", q, 8'hF8);
      tick();
      mode = 3'b110;
      chk8("shr_q2", q, 8'hFC);
      tick();
      mode = 3'b100;
      chk8("shr_q3", q, 8'hFE);
      tick();
      chk8("shr_q4", q, 8'hFF);
      chk1("shr_busy_end", busy, 1'b0);
      tick();
      chk1("shr_done", done, 1'b1);
      tick();
      sin_r = 1'b0;

      // shift_cnt=0: no shift, done pulse only
      mode = 3'b010; shift_cnt = 4'd0; start = 1'b1;
      tick();
      start = 1'b0;
      chk8("cnt0_q", q, 8'hFF);
      chk1("cnt0_busy", busy, 1'b0);
      chk1("cnt0_done_early", done, 1'b0);
      tick();
      chk1("cnt0_done", done, 1'b1);
      chk8("cnt0_q_hold", q, 8'hFF);
      tick();
      chk1("cnt0_done_clear", done, 1'b0);

      // shift_cnt=15 saturates to 8 rotations
      load(8'h01);
      mode = 3'b100; shift_cnt = 4'd15; start = 1'b1;
      exp_q = 8'h01;
      for (int i = 1; i <= 8; i++) begin
         tick();
         start = 1'b0;
         exp_q = {exp_q[6:0], exp_q[7]};
         chk8($sformatf("sat_q%0d", i), q, exp_q);
         chk1($sformatf("sat_busy%0d", i), busy, (i < 8));
      end
      chk8("sat_q_orig", q, 8'h01);
      tick();
      chk1("sat_done", done, 1'b1);
      chk8("sat_q_no_extra", q, 8'h01);
      tick();

      // start held high: rotr by 1 every other cycle
      mode = 3'b101; shift_cnt = 4'd1; start = 1'b1;
      tick();
      chk8("held_q1", q, 8'h80);
      chk1("held_sout_l1", sout_l, 1'b1);
      chk1("held_sout_r1", sout_r, 1'b0);
      chk1("held_done1", done, 1'b0);
      tick();
      chk8("held_q1_fin", q, 8'h80);
      chk1("held_done1_fin", done, 1'b1);
      tick();
      chk8("held_q2", q, 8'h40);
      chk1("held_sout_l2", sout_l, 1'b0);
      chk1("held_done2", done, 1'b0);
      tick();
      chk8("held_q2_fin", q, 8'h40);
      chk1("held_done2_fin", done, 1'b1);
      start = 1'b0;
      tick();

      // reset mid-burst
      mode = 3'b100; shift_cnt = 4'd8; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk1("mid_busy_before", busy, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk8("mid_rst_q", q, 8'h00);
      chk1("mid_rst_busy", busy, 1'b0);
      chk1("mid_rst_done", done, 1'b0);
      tick();
      rst = 1'b0;
      tick();
      chk8("post_rst_q", q, 8'h00);
      chk1("post_rst_busy", busy, 1'b0);
      chk1("post_rst_done", done, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
